// File: rtl/rf_pkg.sv
// Shared defaults for the CPU register bank: width, address size and the
// architectural zero-register index.
package rf_pkg;

   localparam int unsigned DEF_DATA_W = 32'd32;
   localparam int unsigned DEF_ADDR_W = 32'd5;
   localparam int unsigned REG_ZERO   = 32'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, with two raw lookup ports for the hazard unit.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter bit          ZERO_REG0 = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic [ADDR_W-1:0] lk_addr1,
   input  logic [ADDR_W-1:0] lk_addr2,
   output logic              lk_pend1,
   output logic              lk_pend2
);

   localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
   localparam logic [DEPTH-1:0]  ONE       = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0] pend_r;
   logic [DEPTH-1:0] set_mask_s;
   logic [DEPTH-1:0] clr_mask_s;
   logic [DEPTH-1:0] pend_nxt_s;
   logic             set_ok_s;

   // Set is applied after clear so a same-address issue keeps the bit high.
   always_comb begin
      set_ok_s   = set_en && !(ZERO_REG0 && (set_addr == ZERO_ADDR));
      set_mask_s = set_ok_s ? (ONE << set_addr) : {DEPTH{1'b0}};
      clr_mask_s = clr_en ? (ONE << clr_addr) : {DEPTH{1'b0}};
      pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
   end

   // Pending-bit state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_r <= {DEPTH{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
      end
   end

   assign lk_pend1 = pend_r[lk_addr1];
   assign lk_pend2 = pend_r[lk_addr2];

endmodule

// File: rtl/reg_bank_sync.sv
// Two-read/one-write CPU register bank with write bypass, optional zero
// register, optional registered read and a pending-write scoreboard.
module reg_bank_sync
   import rf_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter bit          ZERO_REG0 = 1'b1,
   parameter bit          READ_REG  = 1'b0,
   parameter bit          BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_pend1,
   output logic              rd_pend2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr
);

   localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0] bank_r [DEPTH];
   logic [ADDR_W-1:0] addr_s [2];
   logic [DATA_W-1:0] rdval_s [2];
   logic              hit_s [2];
   logic              zero_s [2];
   logic              raw_pend_s [2];
   logic              wr_ok_s;

   assign addr_s[0] = rd_addr1;
   assign addr_s[1] = rd_addr2;
   assign wr_ok_s   = wr_en && !(ZERO_REG0 && (wr_addr == ZERO_ADDR));

   rf_scoreboard #(
      .ADDR_W    (ADDR_W),
      .ZERO_REG0 (ZERO_REG0)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (iss_en),
      .set_addr (iss_addr),
      .clr_en   (wr_en),
      .clr_addr (wr_addr),
      .lk_addr1 (rd_addr1),
      .lk_addr2 (rd_addr2),
      .lk_pend1 (raw_pend_s[0]),
      .lk_pend2 (raw_pend_s[1])
   );

   // Storage array; a write to the zero register is dropped when it is hardwired.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            bank_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_ok_s) begin
         bank_r[wr_addr] <= wr_data;
      end
   end

   // Read mux: zero register beats bypass, bypass beats the stored value.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         zero_s[p] = ZERO_REG0 && (addr_s[p] == ZERO_ADDR);
         hit_s[p]  = BYPASS && wr_en && (wr_addr == addr_s[p]);
         if (zero_s[p]) begin
            rdval_s[p] = {DATA_W{1'b0}};
         end else if (hit_s[p]) begin
            rdval_s[p] = wr_data;
         end else begin
            rdval_s[p] = bank_r[addr_s[p]];
         end
      end
   end

   assign rd_pend1 = raw_pend_s[0] & ~hit_s[0] & ~zero_s[0];
   assign rd_pend2 = raw_pend_s[1] & ~hit_s[1] & ~zero_s[1];

   generate
      if (READ_REG) begin : g_rreg
         logic [DATA_W-1:0] rd1_r;
         logic [DATA_W-1:0] rd2_r;

         // Output registers capture the (possibly forwarded) read value.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd1_r <= {DATA_W{1'b0}};
               rd2_r <= {DATA_W{1'b0}};
            end else begin
               rd1_r <= rdval_s[0];
               rd2_r <= rdval_s[1];
            end
         end

         assign rd_data1 = rd1_r;
         assign rd_data2 = rd2_r;
      end else begin : g_comb
         assign rd_data1 = rdval_s[0];
         assign rd_data2 = rdval_s[1];
      end
   endgenerate

endmodule
